// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Returns 0 for an illegal WIDTH/CHUNK pair so the top can reject it at elaboration.
  function automatic int calc_nch(input int width, input int chunk);
    if (chunk < 1 || chunk > width || (width % chunk) != 0) begin
      return 0;
    end
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit ripple slice, purely combinational; shared across all slice cycles.
module addsub_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_eff,
  input  logic             carry_in,
  output logic [CHUNK-1:0] s,
  output logic             carry_out,
  output logic             msb_carry_in
);

  logic [CHUNK:0] total;

  assign total        = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_in};
  assign s            = total[CHUNK-1:0];
  assign carry_out    = total[CHUNK];
  // The carry entering the top bit is recovered from its sum bit.
  assign msb_carry_in = a[CHUNK-1] ^ b_eff[CHUNK-1] ^ total[CHUNK-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// WIDTH-bit a+b+cin / a-b-cin, one CHUNK slice per clock; done pulses NCH cycles after accept.
// start is taken only while idle (including the done cycle); starts during RUN are dropped.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1) begin : g_cfg_check
    $error("seq_addsub_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl, msb_ci_sl;
  logic             last;

  assign a_sl = a_q[k_q*CHUNK +: CHUNK];
  assign b_sl = b_q[k_q*CHUNK +: CHUNK];
  assign last = (k_q == KW'(NCH - 1));

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a            (a_sl),
    .b_eff        (b_sl),
    .carry_in     (carry_q),
    .s            (s_sl),
    .carry_out    (c_sl),
    .msb_carry_in (msb_ci_sl)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into an add of ~b with inverted borrow.
          a_d     = a;
          b_d     = (sub == MODE_ADD) ? b : ~b;
          carry_d = (sub == MODE_SUB) ? ~cin : cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[k_q*CHUNK +: CHUNK] = s_sl;
        carry_d = c_sl;
        k_d     = k_q + KW'(1);
        if (last) begin
          state_d = IDLE;
          sum_d   = work_d;
          cout_d  = c_sl;
          ovf_d   = msb_ci_sl ^ c_sl;
          zero_d  = (work_d == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench: three instances (CHUNK 16, 64, 8) share stimulus; latency and results checked per instance.
module tb_seq_addsub_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] sum_w [3];
  logic [2:0]  cout_w, ovf_w, zero_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  int nch_t [3] = '{4, 1, 8};

  seq_addsub_unit #(.WIDTH(64), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  seq_addsub_unit #(.WIDTH(64), .CHUNK(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  seq_addsub_unit #(.WIDTH(64), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]),
    .busy(busy_w[2]), .done(done_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then watches every instance for 12 cycles after acceptance.
  task automatic do_op(input string tag, input logic s, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic [63:0] es, input logic ec, input logic eo,
                       input logic ez);
    int lat [3];
    int nd  [3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1;
      nd[d]  = 0;
    end
    @(negedge clk);
    sub = s; a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; cin = ~ci; sub = ~s;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("%s/d%0d/busy@%0d", tag, d, n), 64'(busy_w[d]), 64'(n < nch_t[d]));
        if (done_w[d]) begin
          nd[d]++;
          if (lat[d] < 0) lat[d] = n;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/d%0d/latency", tag, d), 64'(lat[d]), 64'(nch_t[d]));
      check($sformatf("%s/d%0d/done_pulses", tag, d), 64'(nd[d]), 64'd1);
      check($sformatf("%s/d%0d/sum", tag, d), sum_w[d], es);
      check($sformatf("%s/d%0d/cout", tag, d), 64'(cout_w[d]), 64'(ec));
      check($sformatf("%s/d%0d/ovf", tag, d), 64'(ovf_w[d]), 64'(eo));
      check($sformatf("%s/d%0d/zero", tag, d), 64'(zero_w[d]), 64'(ez));
    end
  endtask

  task automatic check_all_cleared(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s/d%0d/sum", tag, d), sum_w[d], 64'd0);
      check($sformatf("%s/d%0d/flags", tag, d),
            64'({cout_w[d], ovf_w[d], zero_w[d], busy_w[d], done_w[d]}), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_all_cleared("reset");
    rst_n = 1'b1;

    do_op("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    do_op("add_compl", 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op("add_zero", 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    do_op("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000,
          1'b0, 1'b1, 1'b0);
    do_op("sub_borrow", 1'b1, 64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF,
          1'b1, 1'b1, 1'b0);
    do_op("sub_cin", 1'b1, 64'h5, 64'h3, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0);

    // Handshake on the CHUNK=16 instance: a start during RUN is dropped, one in the done cycle is taken.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 64'd1; b = 64'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 64'd100; b = 64'd100;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    check("hs/busy_e2", 64'(busy_w[0]), 64'd1);
    @(negedge clk);
    check("hs/done_e3", 64'(done_w[0]), 64'd0);
    @(negedge clk);
    check("hs/done_e4", 64'(done_w[0]), 64'd1);
    check("hs/busy_e4", 64'(busy_w[0]), 64'd0);
    check("hs/sum1", sum_w[0], 64'd3);
    start = 1'b1; a = 64'd10; b = 64'd20;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    check("hs/busy_e5", 64'(busy_w[0]), 64'd1);
    check("hs/done_e5", 64'(done_w[0]), 64'd0);
    check("hs/sum_hold", sum_w[0], 64'd3);
    repeat (3) @(negedge clk);
    check("hs/done_e8", 64'(done_w[0]), 64'd0);
    @(negedge clk);
    check("hs/done_e9", 64'(done_w[0]), 64'd1);
    check("hs/sum2", sum_w[0], 64'd30);
    repeat (12) @(negedge clk);

    // Reset between E2 and E3 of an op; sum still holds a nonzero earlier result.
    @(negedge clk);
    sub = 1'b0; cin = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_cleared("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check($sformatf("midrst/no_done@%0d", n), 64'(done_w), 64'd0);
    end
    do_op("after_rst", 1'b1, 64'h5, 64'h3, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
